// File: rtl/tsfm_seq_pkg.sv
// Shared types and constants for the Turbosound-FM write sequencer.
package tsfm_seq_pkg;

  // Bus-phase sequencer states; RD_ON is only reachable when reads are built in.
  typedef enum logic [3:0] {
    IDLE,
    SEL_ON,
    SEL_GAP,
    ADR_ON,
    ADR_GAP,
    ADR_WAIT,
    DAT_ON,
    DAT_GAP,
    DAT_WAIT,
    RD_ON
  } seq_state_e;

  localparam logic [7:0] SEL_PREFIX   = 8'hF8;
  localparam logic [7:0] FM_ADDR_BASE = 8'h10;

  // One latched register transaction.
  typedef struct packed {
    logic       chip;
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
  } txn_t;

  // Select word understood by the Turbosound-FM block: low bits carry
  // FM-disable, status-select and chip number.
  function automatic logic [7:0] sel_word(input logic fm_en, input logic stat,
                                          input logic chip);
    return SEL_PREFIX | {5'b0, ~fm_en, stat, chip};
  endfunction

  // Addresses from 0x10 upward belong to the FM part and need busy waits.
  function automatic logic is_fm(input logic [7:0] addr);
    return addr >= FM_ADDR_BASE;
  endfunction

endpackage

// File: rtl/tsfm_write_sequencer_timer.sv
// tsfm_phase_timer: loadable down-counter timing the ON, GAP and WAIT phases.
// In CLK mode it decrements every cycle; in CE mode only on CE pulses.
// It saturates at zero and done is high while the count is zero.
module tsfm_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CE,
  input  logic             load,
  input  logic             ce_mode,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic             ce_mode_q;

  // Load a new phase length, otherwise count down towards zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: state is written with <= so every flop samples pre-edge values.
    if (!RESET_N) begin
      cnt_q     <= '0;
      ce_mode_q <= 1'b0;
    end else if (load) begin
      cnt_q     <= load_val;
      ce_mode_q <= ce_mode;
    end else if ((cnt_q != '0) && (!ce_mode_q || CE)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tsfm_write_sequencer.sv
// tsfm_write_sequencer: arbitrates two register-write requesters and turns
// each transaction into BDIR/BC/DI bus phases for the Turbosound-FM block,
// holding off for YM2203 busy time after FM accesses.
// Optional build macro TSFM_SEQ_READ_EN adds port-A register reads.
module tsfm_write_sequencer #(
  parameter int PULSE_CLKS   = 4,
  parameter int GAP_CLKS     = 4,
  parameter int ADDR_WAIT_CE = 17,
  parameter int DATA_WAIT_CE = 83
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic       fm_enable,
  input  logic       stat_sel,
  input  logic       a_req,
  output logic       a_ack,
  input  logic       a_chip,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_data,
`ifdef TSFM_SEQ_READ_EN
  input  logic       a_rd,
  output logic [7:0] a_rdata,
  input  logic [7:0] DO,
`endif
  input  logic       b_req,
  output logic       b_ack,
  input  logic       b_chip,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_data,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DI,
  output logic       busy
);

  import tsfm_seq_pkg::*;

  localparam int MAX_PH  = (PULSE_CLKS > GAP_CLKS) ? PULSE_CLKS : GAP_CLKS;
  localparam int MAX_WT  = (ADDR_WAIT_CE > DATA_WAIT_CE) ? ADDR_WAIT_CE : DATA_WAIT_CE;
  localparam int CNT_W   = $clog2(((MAX_PH > MAX_WT) ? MAX_PH : MAX_WT) + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CLKS - 1);
  localparam logic [CNT_W-1:0] ADR_LD   = CNT_W'(ADDR_WAIT_CE);
  localparam logic [CNT_W-1:0] DAT_LD   = CNT_W'(DATA_WAIT_CE);

  seq_state_e state_q, state_d;
  txn_t       txn_q, win;
  logic       fm_q, stat_q, owner_b_q;
  logic       sel_valid_q, cur_chip_q, cur_fm_q, cur_stat_q;
  logic [2:0] b_loss_q;
  logic       grant_a, grant_b, grant_any, need_sel;
  logic       tmr_load, tmr_ce_mode, tmr_done, txn_done;
  logic [CNT_W-1:0] tmr_val;

  // Arbitration: A has priority unless B has lost four times in a row.
  always_comb begin
    grant_b   = (state_q == IDLE) && b_req && (!a_req || (b_loss_q == 3'd4));
    grant_a   = (state_q == IDLE) && a_req && !grant_b;
    grant_any = grant_a || grant_b;
  end

  // Winner's fields and whether the target's select state must be refreshed.
  always_comb begin
    win = '0;
    if (grant_b) begin
      win.chip = b_chip;
      win.addr = b_addr;
      win.data = b_data;
    end else begin
      win.chip = a_chip;
      win.addr = a_addr;
      win.data = a_data;
`ifdef TSFM_SEQ_READ_EN
      win.rd   = a_rd;
`endif
    end
    need_sel = !sel_valid_q || (win.chip != cur_chip_q) ||
               (fm_enable != cur_fm_q) || (stat_sel != cur_stat_q);
  end

  // Next-state logic and phase-timer loading.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_ce_mode = 1'b0;
    tmr_val     = '0;
    txn_done    = 1'b0;
    unique case (state_q)
      IDLE: if (grant_any) begin
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
        state_d  = need_sel ? SEL_ON : ADR_ON;
      end
      SEL_ON: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LD;
        state_d  = SEL_GAP;
      end
      SEL_GAP: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
        state_d  = ADR_ON;
      end
      ADR_ON: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LD;
        state_d  = ADR_GAP;
      end
      ADR_GAP: if (tmr_done) begin
        tmr_load    = 1'b1;
        tmr_ce_mode = 1'b1;
        tmr_val     = is_fm(txn_q.addr) ? ADR_LD : '0;
        state_d     = ADR_WAIT;
      end
      ADR_WAIT: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
        state_d  = txn_q.rd ? RD_ON : DAT_ON;
      end
      DAT_ON: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LD;
        state_d  = DAT_GAP;
      end
      DAT_GAP: if (tmr_done) begin
        tmr_load    = 1'b1;
        tmr_ce_mode = 1'b1;
        // With FM disabled the target drops the write, so no busy time follows.
        tmr_val     = (is_fm(txn_q.addr) && fm_q) ? DAT_LD : '0;
        state_d     = DAT_WAIT;
      end
      DAT_WAIT, RD_ON: if (tmr_done) begin
        txn_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch the winning transaction and the config it will be issued with.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      txn_q     <= '0;
      fm_q      <= 1'b0;
      stat_q    <= 1'b1;
      owner_b_q <= 1'b0;
    end else if (grant_any) begin
      txn_q     <= win;
      fm_q      <= fm_enable;
      stat_q    <= stat_sel;
      owner_b_q <= grant_b;
    end
  end

  // Shadow of the target's select state, committed once SEL_ON completes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sel_valid_q <= 1'b0;
      cur_chip_q  <= 1'b1;
      cur_fm_q    <= 1'b0;
      cur_stat_q  <= 1'b1;
    end else if ((state_q == SEL_ON) && tmr_done) begin
      sel_valid_q <= 1'b1;
      cur_chip_q  <= txn_q.chip;
      cur_fm_q    <= fm_q;
      cur_stat_q  <= stat_q;
    end
  end

  // Count consecutive arbitrations B lost to A.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                b_loss_q <= 3'd0;
    else if (grant_b)            b_loss_q <= 3'd0;
    else if (grant_a && b_req)   b_loss_q <= b_loss_q + 3'd1;
  end

  // One-cycle acknowledge to the owner, in the first cycle back in IDLE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
    end else begin
      a_ack <= txn_done && !owner_b_q;
      b_ack <= txn_done && owner_b_q;
    end
  end

`ifdef TSFM_SEQ_READ_EN
  // Capture the target's read data on the last RD_ON cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                             a_rdata <= 8'h00;
    else if ((state_q == RD_ON) && tmr_done)  a_rdata <= DO;
  end
`endif

  // Bus phase decode; DI stays valid through each ON phase and its GAP.
  always_comb begin
    BDIR = 1'b0;
    BC   = 1'b0;
    DI   = 8'h00;
    unique case (state_q)
      SEL_ON:   begin BDIR = 1'b1; BC = 1'b1; DI = sel_word(fm_q, stat_q, txn_q.chip); end
      SEL_GAP:  DI = sel_word(fm_q, stat_q, txn_q.chip);
      ADR_ON:   begin BDIR = 1'b1; BC = 1'b1; DI = txn_q.addr; end
      ADR_GAP:  DI = txn_q.addr;
      DAT_ON:   begin BDIR = 1'b1; DI = txn_q.data; end
      DAT_GAP:  DI = txn_q.data;
      RD_ON:    BC = 1'b1;
      default:  ;
    endcase
  end

  assign busy = (state_q != IDLE);

  tsfm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CE       (CE),
    .load     (tmr_load),
    .ce_mode  (tmr_ce_mode),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

endmodule
